// File: rtl/inst_fetch.sv
// inst_fetch: MIPS fetch stage, req/ack instruction memory port and valid/ready decode handoff.
// Define FETCH_STATS_EN to add the fetch_count/stall_count counters.
module inst_fetch #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [5:0]          op,
    output logic [5:0]          func,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm,
`ifdef FETCH_STATS_EN
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count,
`endif
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_target
);
    localparam logic [1:0] S_REQ = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2;
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc, stale, tgt;
    logic [31:0]         instr;
    logic                live, ack;

    // live keeps the request low until the first edge after reset release
    assign imem_req  = live & (state != S_HOLD);
    assign imem_addr = (state == S_DRAIN) ? stale : pc;
    assign ack       = imem_ack & imem_req;
    assign tgt       = redirect_target & ALIGN;
    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign imm       = instr[15:0];
    assign func      = instr[5:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC & ALIGN;
            stale    <= '0;
            id_pc    <= '0;
            instr    <= '0;
            id_valid <= 1'b0;
            live     <= 1'b0;
        end else begin
            live <= 1'b1;
            if (state == S_REQ) begin
                if (redirect) begin
                    pc <= tgt;
                    if (imem_req && !imem_ack) begin
                        stale <= pc;
                        state <= S_DRAIN;
                    end
                end else if (ack) begin
                    instr    <= imem_rdata;
                    id_pc    <= pc;
                    pc       <= pc + PC_WIDTH'(4);
                    id_valid <= 1'b1;
                    state    <= S_HOLD;
                end
            end else if (state == S_HOLD) begin
                if (redirect || id_ready) begin
                    id_valid <= 1'b0;
                    state    <= S_REQ;
                end
                if (redirect) pc <= tgt;
            end else begin
                // outstanding stale transaction: wait for its ack, then refetch at the latest pc
                if (redirect) pc <= tgt;
                if (imem_ack) state <= S_REQ;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (id_valid && id_ready) fetch_count <= fetch_count + 32'd1;
            if (imem_req && !imem_ack) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
